// File: rtl/sd_cmd_engine.sv
// ---------------------------------------------------------------------------
// sd_cmd_engine
//   Issues one SD-bus command frame (48 bits, CRC7-protected) on the CMD line
//   and, when requested, collects the card's 48-bit response frame.
//
//   Frame on the wire, MSB first:
//     0, 1, cmd_idx[5:0], cmd_arg[31:0], CRC7[6:0], 1
//
//   Sequence: IDLE -> SEND (48) -> [GAP (2) -> WAIT (<=TIMEOUT_CYC) -> RECV (47)]
//             -> FIN (done pulse) -> IDLE
//
// Ports
//   sd_clk       in   SD clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   issue one command (sampled only in IDLE)
//   cmd_idx      in   6-bit command index, captured with start
//   cmd_arg      in   32-bit command argument, captured with start
//   expect_resp  in   collect a 48-bit response after the command
//   crc_chk      in   verify response CRC7 (0 for R3-type responses)
//   sd_cmd_in    in   CMD line from card
//   sd_cmd_out   out  CMD line to card, idles high
//   busy         out  high in every state except IDLE
//   done         out  one-cycle completion pulse
//   resp         out  last received response frame, MSB = start bit
//   crc_err      out  response CRC7 / end-bit error, valid with done
//   timeout      out  no response start bit seen, valid with done
// ---------------------------------------------------------------------------
module sd_cmd_engine #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        sd_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic        expect_resp,
    input  logic        crc_chk,
    input  logic        sd_cmd_in,
    output logic        sd_cmd_out,
    output logic        busy,
    output logic        done,
    output logic [47:0] resp,
    output logic        crc_err,
    output logic        timeout
);

    localparam int FRAME_BITS = 48;
    localparam int GAP_CYC    = 2;
    localparam int CNT_MAX    = (TIMEOUT_CYC > FRAME_BITS) ? TIMEOUT_CYC : FRAME_BITS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT, RECV, FIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [47:0]      tx_shift;
    logic             expect_resp_q;
    logic             crc_chk_q;
    logic [47:0]      rx_next;

    // CRC7, polynomial x^7 + x^3 + 1, initial value 0, over 40 bits MSB first.
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            // NOTE: blocking assignments are correct here: each iteration must
            // see the value produced by the previous one, all within one evaluation.
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Response shift value including the bit on the line this cycle; on the
    // final RECV cycle this is the complete frame that gets checked.
    assign rx_next = {resp[46:0], sd_cmd_in};

    // ---------------- state register ----------------
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and
        // no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = SEND;
            SEND: if (cnt == CNT_W'(FRAME_BITS - 1))
                      state_next = expect_resp_q ? GAP : FIN;
            GAP:  if (cnt == CNT_W'(GAP_CYC - 1)) state_next = WAIT;
            WAIT: if (!sd_cmd_in)                         state_next = RECV;
                  else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) state_next = FIN;
            RECV: if (cnt == CNT_W'(FRAME_BITS - 2)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        sd_cmd_out = 1'b1;
        busy       = (state != IDLE);
        done       = (state == FIN);
        if (state == SEND) sd_cmd_out = tx_shift[47];
    end

    // ---------------- datapath ----------------
    // The counter is reused by SEND, GAP, WAIT and RECV and is cleared on
    // every exit so each state starts counting from 0.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            tx_shift      <= '0;
            expect_resp_q <= 1'b0;
            crc_chk_q     <= 1'b0;
            resp          <= '0;
            crc_err       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift      <= {2'b01, cmd_idx, cmd_arg,
                                          crc7({2'b01, cmd_idx, cmd_arg}), 1'b1};
                        expect_resp_q <= expect_resp;
                        crc_chk_q     <= crc_chk;
                        crc_err       <= 1'b0;
                        timeout       <= 1'b0;
                        cnt           <= '0;
                    end
                end
                SEND: begin
                    tx_shift <= {tx_shift[46:0], 1'b1};
                    cnt      <= (cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : cnt + CNT_W'(1);
                end
                GAP: begin
                    // Line is deliberately not sampled here (N_CR minimum).
                    cnt <= (cnt == CNT_W'(GAP_CYC - 1)) ? '0 : cnt + CNT_W'(1);
                end
                WAIT: begin
                    if (!sd_cmd_in) begin
                        resp <= rx_next;        // start bit lands in bit 0, ends at bit 47
                        cnt  <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RECV: begin
                    resp <= rx_next;
                    if (cnt == CNT_W'(FRAME_BITS - 2)) begin
                        crc_err <= !rx_next[0] ||
                                   (crc_chk_q && (rx_next[7:1] != crc7(rx_next[47:8])));
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIN: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_engine
//   Directed bench for sd_cmd_engine: CMD0, CMD8 with response, silent card,
//   corrupted response CRC with and without checking, reset mid-transfer and
//   start held high. Expected frames are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sd_cmd_engine;

    logic        sd_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        expect_resp;
    logic        crc_chk;
    logic        sd_cmd_in;
    logic        sd_cmd_out;
    logic        busy;
    logic        done;
    logic [47:0] resp;
    logic        crc_err;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] CMD0_FRAME  = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD8_FRAME  = 48'h48_0000_01AA_87;
    localparam logic [47:0] R7_GOOD     = 48'h08_0000_01AA_13;
    localparam logic [47:0] R7_BAD_CRC  = 48'h08_0000_01AA_15;

    sd_cmd_engine #(.TIMEOUT_CYC(64)) dut (
        .sd_clk      (sd_clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmd_idx     (cmd_idx),
        .cmd_arg     (cmd_arg),
        .expect_resp (expect_resp),
        .crc_chk     (crc_chk),
        .sd_cmd_in   (sd_cmd_in),
        .sd_cmd_out  (sd_cmd_out),
        .busy        (busy),
        .done        (done),
        .resp        (resp),
        .crc_err     (crc_err),
        .timeout     (timeout)
    );

    always #5 sd_clk = ~sd_clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge sd_clk);
        #1;
    endtask

    // Start a command and capture the 48 transmitted bits. Returns in the
    // cycle right after the end bit.
    task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                         input logic exp_r, input logic chk,
                         output logic [47:0] frame);
        start       = 1'b1;
        cmd_idx     = idx;
        cmd_arg     = arg;
        expect_resp = exp_r;
        crc_chk     = chk;
        tick();
        start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            frame[47 - i] = sd_cmd_out;
            tick();
        end
    endtask

    // Called in the cycle after the end bit; places the response start bit
    // 'delay' cycles after the end bit, then one bit per cycle.
    task automatic card_reply(input int delay, input logic [47:0] frame);
        sd_cmd_in = 1'b1;
        repeat (delay - 1) tick();
        for (int i = 47; i >= 0; i--) begin
            sd_cmd_in = frame[i];
            tick();
        end
        sd_cmd_in = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] frame;
        int          cnt_a;
        int          cnt_b;

        rst_n       = 1'b0;
        start       = 1'b0;
        cmd_idx     = '0;
        cmd_arg     = '0;
        expect_resp = 1'b0;
        crc_chk     = 1'b0;
        sd_cmd_in   = 1'b1;

        // ---- reset state ----
        repeat (2) tick();
        check("rst_cmd_out", 48'(sd_cmd_out), 48'd1);
        check("rst_busy",    48'(busy),       48'd0);
        check("rst_done",    48'(done),       48'd0);
        check("rst_resp",    resp,            48'd0);
        check("rst_crc_err", 48'(crc_err),    48'd0);
        check("rst_timeout", 48'(timeout),    48'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---- CMD0, no response ----
        issue(6'd0, 32'h0, 1'b0, 1'b0, frame);
        check("cmd0_frame", frame, CMD0_FRAME);
        check("cmd0_done",  48'(done), 48'd1);
        check("cmd0_busy_fin", 48'(busy), 48'd1);
        tick();
        check("cmd0_done_off", 48'(done), 48'd0);
        check("cmd0_busy_off", 48'(busy), 48'd0);
        check("cmd0_line_idle", 48'(sd_cmd_out), 48'd1);

        // ---- CMD8 with good R7 response, start bit 5 cycles after end bit ----
        issue(6'd8, 32'h1AA, 1'b1, 1'b1, frame);
        check("cmd8_frame", frame, CMD8_FRAME);
        check("cmd8_gap_line", 48'(sd_cmd_out), 48'd1);
        card_reply(5, R7_GOOD);
        check("cmd8_done",    48'(done),    48'd1);
        check("cmd8_resp",    resp,         R7_GOOD);
        check("cmd8_crc_err", 48'(crc_err), 48'd0);
        check("cmd8_timeout", 48'(timeout), 48'd0);
        tick();
        check("cmd8_busy_off", 48'(busy), 48'd0);

        // ---- silent card: GAP 2 + WAIT 64 cycles, then FIN ----
        issue(6'd8, 32'h1AA, 1'b1, 1'b1, frame);
        cnt_a = 0;
        for (int i = 0; i < 66; i++) begin
            if (done) cnt_a++;
            tick();
        end
        check("silent_early_done", 48'(cnt_a),   48'd0);
        check("silent_done",       48'(done),    48'd1);
        check("silent_timeout",    48'(timeout), 48'd1);
        check("silent_crc_err",    48'(crc_err), 48'd0);
        check("silent_resp_kept",  resp,         R7_GOOD);
        tick();
        check("silent_timeout_hold", 48'(timeout), 48'd1);

        // ---- corrupted CRC, checking enabled ----
        issue(6'd8, 32'h1AA, 1'b1, 1'b1, frame);
        card_reply(5, R7_BAD_CRC);
        check("badcrc_done",    48'(done),    48'd1);
        check("badcrc_crc_err", 48'(crc_err), 48'd1);
        check("badcrc_timeout", 48'(timeout), 48'd0);
        check("badcrc_resp",    resp,         R7_BAD_CRC);
        tick();

        // ---- corrupted CRC, checking disabled ----
        issue(6'd8, 32'h1AA, 1'b1, 1'b0, frame);
        card_reply(5, R7_BAD_CRC);
        check("nochk_done",    48'(done),    48'd1);
        check("nochk_crc_err", 48'(crc_err), 48'd0);
        tick();

        // ---- reset asserted at SEND bit 20 ----
        start       = 1'b1;
        cmd_idx     = 6'd0;
        cmd_arg     = 32'h0;
        expect_resp = 1'b0;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("abort_busy_before", 48'(busy), 48'd1);
        rst_n = 1'b0;
        #1;
        check("abort_cmd_out", 48'(sd_cmd_out), 48'd1);
        check("abort_busy",    48'(busy),       48'd0);
        check("abort_done",    48'(done),       48'd0);
        check("abort_resp",    resp,            48'd0);
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) cnt_a++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) cnt_a++;
        end
        check("abort_no_done", 48'(cnt_a), 48'd0);

        // ---- start held high: one command per IDLE visit ----
        start       = 1'b1;
        expect_resp = 1'b0;
        tick();
        cnt_a = 0;   // done pulses
        cnt_b = 0;   // idle cycles
        for (int i = 0; i < 100; i++) begin
            if (done)  cnt_a++;
            if (!busy) cnt_b++;
            tick();
        end
        start = 1'b0;
        check("held_done_count", 48'(cnt_a), 48'd2);
        check("held_idle_count", 48'(cnt_b), 48'd2);
        cnt_a = 0;
        for (int i = 0; i < 60 && !done; i++) tick();
        check("held_drain_done", 48'(done), 48'd1);
        tick();
        check("held_final_idle", 48'(busy), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, the maximum number of sd_clk cycles spent waiting for a response start bit.
REQ-002 SHALL have port sd_clk  input  1  SD clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to issue one command; sampled only in IDLE.
REQ-005 SHALL have port cmd_idx  input  6  command index, captured with start.
REQ-006 SHALL have port cmd_arg  input  32  command argument, captured with start.
REQ-007 SHALL have port expect_resp  input  1  1 = collect a 48-bit response after sending; captured with start.
REQ-008 SHALL have port crc_chk  input  1  1 = verify response CRC7 (R1/R7); 0 = skip the check (R3); captured with start.
REQ-009 SHALL have port sd_cmd_in  input  1  CMD line from card.
REQ-010 SHALL have port sd_cmd_out  output  1  CMD line to card; idles high.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp  output  48  last received response frame, MSB = start bit.
REQ-014 SHALL have port crc_err  output  1  response CRC7 or end-bit error, valid with done.
REQ-015 SHALL have port timeout  output  1  no response start bit seen, valid with done.

Function
REQ-016 SHALL build the TX frame as 0, 1, cmd_idx[5:0], cmd_arg[31:0], CRC7[6:0], 1 and transmit it MSB first.
REQ-017 SHALL compute CRC7 with polynomial x^7+x^3+1 and initial value 0 over frame bits 47..8.
REQ-018 SHALL implement the states IDLE, SEND, GAP, WAIT, RECV and FIN.
REQ-019 IDLE: when start=1, SHALL capture the inputs, clear crc_err and timeout, and enter SEND; sd_cmd_out SHALL carry frame bit 47 in the following cycle.
REQ-020 SEND: SHALL shift out one bit per cycle for exactly 48 cycles, then go to GAP if expect_resp=1, otherwise to FIN.
REQ-021 GAP: SHALL hold sd_cmd_out=1 for 2 cycles (N_CR minimum) without sampling sd_cmd_in, then enter WAIT.
REQ-022 WAIT: SHALL sample sd_cmd_in each cycle; on 0, SHALL store bit 47 and enter RECV; after TIMEOUT_CYC cycles with no 0, SHALL set timeout=1 and enter FIN.
REQ-023 RECV: SHALL shift in bits 46..0 over 47 cycles into resp, then enter FIN.
REQ-024 At the end of RECV, crc_err SHALL be set if resp[0]!=1, or if crc_chk=1 and resp[7:1] differs from CRC7 of resp[47:8].
REQ-025 FIN: SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 sd_cmd_out SHALL be 1 in every state except SEND.
REQ-027 SHALL ignore start while busy=1; a start in the same cycle as the done pulse SHALL also be ignored.
REQ-028 resp, crc_err and timeout SHALL hold their values until the next accepted start.
REQ-029 If a response start bit arrives during GAP, it SHALL NOT be sampled; the frame SHALL be treated as absent or late.

Reset
REQ-030 When rst_n=0, the block SHALL immediately enter IDLE with sd_cmd_out=1, busy=0, done=0, resp=0, crc_err=0, timeout=0 and all counters at 0.
REQ-031 Reset asserted mid-SEND or mid-RECV SHALL abort the transfer without emitting a done pulse.

Verification
REQ-032 CMD0 stimulus: cmd_idx=0, arg=0, expect_resp=0 -> sd_cmd_out carries 0x40_00000000_95 over 48 cycles; done pulses 1 cycle after the last bit; busy=0 afterwards.
REQ-033 CMD8 stimulus: idx=8, arg=0x1AA, expect_resp=1, crc_chk=1; card replies 0x08_000001AA_13 with its start bit 5 cycles after the end bit -> TX frame is 0x48_000001AA_87, resp=0x08000001AA13, crc_err=0, timeout=0.
REQ-034 Silent card: expect_resp=1 and sd_cmd_in held at 1 -> after 2+64 cycles, done pulses with timeout=1 and resp unchanged.
REQ-035 Corrupted response: the CMD8 reply with its CRC byte changed to 0x15 -> crc_err=1; the same corruption with crc_chk=0 -> crc_err=0.
REQ-036 Reset and collisions: rst_n pulsed low at SEND bit 20 -> sd_cmd_out=1 and busy=0 immediately, with no done pulse; start held high throughout a transfer -> exactly one command is sent per IDLE visit.
